div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 33 +++
 rtl/div.sv | 149 ++++++++++++++
 tb/tb_div.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the iterative divider.
//   - div_state_e : FSM state encodings DivFree / DivByZero / DivOn / DivEnd
//   - DivResultReady / DivResultNotReady : levels of ready_o
//   - DivStart / DivStop : levels of start_i
//   - double_reg_bus_t : 64-bit {remainder, quotient} result bus
//   - abs_operand() : operand magnitude, used when loading a signed divide
package div_pkg;

  localparam int RegBusWidth       = 32;
  localparam int DoubleRegBusWidth = 64;

  typedef logic [RegBusWidth-1:0]       reg_bus_t;
  typedef logic [DoubleRegBusWidth-1:0] double_reg_bus_t;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Magnitude of an operand. In unsigned mode the value passes through.
  // 0x80000000 maps to itself, which the unsigned core reads as 2^31.
  function automatic reg_bus_t abs_operand(input logic is_signed, input reg_bus_t value);
    return (is_signed && value[RegBusWidth-1]) ? reg_bus_t'(-value) : value;
  endfunction

endpackage

// File: rtl/div.sv
// Iterative 32-bit restoring divider, one quotient bit per clock.
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   signed_div_i 1 = two's-complement divide, 0 = unsigned
//   opdata1_i    dividend, captured when a request is accepted
//   opdata2_i    divisor, captured when a request is accepted
//   start_i      request; held high until ready_o has been seen
//   annul_i      cancel the operation in progress
//   result_o     {remainder[63:32], quotient[31:0]}, registered
//   ready_o      result valid, registered
// Latency: accept at edge E0 -> ready_o after E0+33 (E0+2 for divisor 0).
module div
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [31:0]     opdata1_i,
  input  logic [31:0]     opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [63:0]     result_o,
  output logic            ready_o
);

  div_state_e state, state_nxt;

  logic [5:0] cnt;
  reg_bus_t   rem_q;      // partial remainder
  reg_bus_t   quo_q;      // dividend bits shift out, quotient bits shift in
  reg_bus_t   divisor_q;
  logic       neg_quo;    // operand signs differed in signed mode
  logic       neg_rem;    // dividend was negative in signed mode

  logic       accept;
  logic       abort;
  logic       done;
  logic [33:0] diff;
  reg_bus_t   quo_fix;
  reg_bus_t   rem_fix;

  assign accept = (start_i == DivStart) && !annul_i;
  // Dropping start mid-divide means the requester has gone away: same as annul.
  assign abort  = annul_i || (start_i == DivStop);
  assign done   = (cnt == 6'd32);

  // Trial subtraction of {rem, next dividend bit} - divisor. Two guard bits
  // because the shifted partial remainder itself can need 33 bits.
  assign diff = {1'b0, rem_q, quo_q[31]} - {2'b00, divisor_q};

  assign quo_fix = neg_quo ? reg_bus_t'(-quo_q) : quo_q;
  assign rem_fix = neg_rem ? reg_bus_t'(-rem_q) : rem_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= DivFree;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      DivFree: begin
        if (accept) state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
      end
      DivByZero: state_nxt = DivEnd;
      DivOn: begin
        if (abort)     state_nxt = DivFree;
        else if (done) state_nxt = DivEnd;
      end
      DivEnd: begin
        if (start_i == DivStop) state_nxt = DivFree;
      end
      default: state_nxt = DivFree;
    endcase
  end

  // NOTE: every datapath register is reset, not only the outputs, so an
  // aborted divide leaves nothing that could leak into the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (accept && (opdata2_i != '0)) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= abs_operand(signed_div_i, opdata1_i);
            divisor_q <= abs_operand(signed_div_i, opdata2_i);
            neg_quo   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem   <= signed_div_i && opdata1_i[31];
          end
        end
        DivByZero: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
        DivOn: begin
          if (abort) begin
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (done) begin
            cnt      <= '0;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= DivResultReady;
          end else begin
            // diff[33] is the borrow: set means the divisor did not fit.
            if (diff[33]) begin
              rem_q <= {rem_q[30:0], quo_q[31]};
              quo_q <= {quo_q[30:0], 1'b0};
            end else begin
              rem_q <= diff[31:0];
              quo_q <= {quo_q[30:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            ready_o  <= DivResultReady;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: latency, results in both modes,
// divide by zero, annul, start dropped mid-divide, and reset mid-divide.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
  endtask

  // The next rising edge is the accepting edge E0. Operands are scrambled
  // a few cycles in to show they are no longer looked at.
  task automatic wait_ready(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int lat = -1;
    logic [63:0] res;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = n - 1;
        break;
      end
      if (n == 3) begin
        opdata1_i = 32'hDEADBEEF;
        opdata2_i = 32'h0;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp_res);
    res = result_o;
    @(posedge clk);
    #1;
    check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_result"}, result_o, exp_res);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    launch(sgn, a, b);
    wait_ready(tag, exp_lat, exp_res);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 64'(ready_o), 64'd0);

    // {remainder, quotient}
    run("u_100_7",   1'b0, 32'd100,        32'd7,          33, {32'd2, 32'd14});
    run("s_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run("u_fff9_2",  1'b0, 32'hFFFFFFF9,   32'd2,          33, {32'd1, 32'h7FFFFFFC});
    run("s_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   33, {32'd1, 32'hFFFFFFFD});
    run("s_m7_m2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   33, {32'hFFFFFFFF, 32'd3});
    run("u_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          33, {32'd0, 32'hFFFFFFFF});
    run("s_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   33, {32'd0, 32'h80000000});
    run("s_5_0",     1'b1, 32'd5,          32'd0,          2,  64'd0);
    run("u_5_0",     1'b0, 32'd5,          32'd0,          2,  64'd0);

    // Annul at ON cycle 10, then an immediate new request.
    launch(1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i   = 1'b0;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    wait_ready("annul_restart", 33, {32'd0, 32'd3});

    // start_i dropped mid-divide behaves as annul.
    launch(1'b0, 32'd100, 32'd7);
    repeat (6) @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stop_ready", 64'(ready_o), 64'd0);
    check("stop_result", result_o, 64'd0);

    // Reset at ON cycle 20, then a signed request must still be correct.
    launch(1'b0, 32'd1000, 32'd10);
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst          = 1'b0;
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFFFF9C;  // -100
    opdata2_i    = 32'd7;
    wait_ready("post_rst", 33, {32'hFFFFFFFE, 32'hFFFFFFF2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
